// File: rtl/seq_divider_pkg.sv
// Shared definitions for the iterative restoring divider: FSM state encoding
// and the iteration-counter width helper.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Counter holds N down to 1, so it needs one bit beyond $clog2(N).
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bus of the sequential divider.
interface seq_divider_if #(
    parameter int N = 32
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_sub.sv
// Combinational N-bit subtractor (a - b) built from 4-bit carry-lookahead
// groups; N must be a multiple of 4.
module seq_divider_sub #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff
);
    localparam int GROUPS = N / 4;

    logic [N-1:0]    b_inv;
    logic [N-1:0]    gen;
    logic [N-1:0]    prop;
    logic [GROUPS:0] carry;

    // a - b == a + ~b + 1, so the chain starts with a carry-in of one.
    assign b_inv    = ~b;
    assign gen      = a & b_inv;
    assign prop     = a ^ b_inv;
    assign carry[0] = 1'b1;

    for (genvar gi = 0; gi < GROUPS; gi++) begin : g_grp
        logic [3:0] g4;
        logic [3:0] p4;
        logic [4:0] c4;

        assign g4    = gen[gi*4 +: 4];
        assign p4    = prop[gi*4 +: 4];
        assign c4[0] = carry[gi];
        assign c4[1] = g4[0] | (p4[0] & c4[0]);
        assign c4[2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & c4[0]);
        assign c4[3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
                     | (p4[2] & p4[1] & p4[0] & c4[0]);
        assign c4[4] = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
                     | (p4[3] & p4[2] & p4[1] & g4[0])
                     | (p4[3] & p4[2] & p4[1] & p4[0] & c4[0]);

        assign diff[gi*4 +: 4] = p4 ^ c4[3:0];
        assign carry[gi+1]     = c4[4];
    end
endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one shared subtractor sequenced over
// N cycles, with a start/busy/done handshake and divide-by-zero flag.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    seq_divider_if.slave bus
);
    localparam int CNT_W = cnt_width(N);
    localparam int SUB_W = N + 4;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             zero_div;
    logic             last_iter;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0]     q_sh;
    logic [N-1:0]     r_part;
    logic [N-1:0]     dvs;
    logic             dbz_pend;
    logic [N:0]       trial;
    logic [SUB_W-1:0] sub_a;
    logic [SUB_W-1:0] sub_b;
    logic [SUB_W-1:0] sub_diff;
    logic             no_borrow;
    logic             sub_unused;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [N-1:0]     quo_q;
    logic [N-1:0]     rem_q;

    // The partial remainder is always below the divisor, so its top bit is
    // never set and only N bits are stored; the trial value is N+1 bits.
    assign zero_div   = (bus.divisor == '0);
    assign last_iter  = (cnt == CNT_W'(1));
    assign trial      = {r_part, q_sh[N-1]};
    assign sub_a      = {3'b000, trial};
    assign sub_b      = {4'b0000, dvs};
    assign no_borrow  = ~sub_diff[N];
    assign sub_unused = ^sub_diff[SUB_W-1:N+1];

    seq_divider_sub #(.N(SUB_W)) u_sub (
        .a    (sub_a),
        .b    (sub_b),
        .diff (sub_diff)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = zero_div ? FINISH : RUN;
                end
            end
            RUN:     if (last_iter) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            quo_q    <= '0;
            rem_q    <= '0;
            cnt      <= '0;
            dbz_pend <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                busy_q   <= 1'b1;
                dbz_q    <= 1'b0;
                cnt      <= CNT_W'(N);
                dbz_pend <= zero_div;
            end else if (state == RUN && !last_iter) begin
                cnt <= cnt - CNT_W'(1);
            end
            // A zero-divisor request skips RUN, so q_sh still holds the dividend.
            if (state == FINISH) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
                dbz_q  <= dbz_pend;
                quo_q  <= dbz_pend ? '1   : q_sh;
                rem_q  <= dbz_pend ? q_sh : r_part;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            q_sh   <= bus.dividend;
            r_part <= '0;
            dvs    <= bus.divisor;
        end else if (state == RUN) begin
            r_part <= no_borrow ? sub_diff[N-1:0] : trial[N-1:0];
            q_sh   <= {q_sh[N-2:0], no_borrow};
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed literal cases plus randomized
// operands compared every cycle against a cycle-count/arithmetic model.
`timescale 1ns/1ps
module tb_seq_divider;
    localparam int N = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_divider_if #(.N(N)) bus ();

    seq_divider #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: a request accepted while idle produces q = a/b,
    // r = a%b (or all-ones / dividend for b==0) after a fixed latency.
    int           cyc = 0;
    bit           m_live = 1'b0;
    bit           m_pend = 1'b0;
    int           m_done_at = 0;
    logic [N-1:0] m_q, m_r;
    bit           m_z;
    bit           e_busy, e_done, e_dbz;
    logic [N-1:0] e_q, e_r;
    int           n_acc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_live <= 1'b1;
            m_pend <= 1'b0;
            e_busy <= 1'b0;
            e_done <= 1'b0;
            e_dbz  <= 1'b0;
            e_q    <= '0;
            e_r    <= '0;
        end else begin
            e_done <= 1'b0;
            if (m_pend && cyc == m_done_at) begin
                m_pend <= 1'b0;
                e_busy <= 1'b0;
                e_done <= 1'b1;
                e_q    <= m_q;
                e_r    <= m_r;
                e_dbz  <= m_z;
            end
            if (!m_pend && bus.start === 1'b1) begin
                m_pend <= 1'b1;
                e_busy <= 1'b1;
                e_dbz  <= 1'b0;
                n_acc  <= n_acc + 1;
                if (bus.divisor == '0) begin
                    m_q       <= '1;
                    m_r       <= bus.dividend;
                    m_z       <= 1'b1;
                    m_done_at <= cyc + 1;
                end else begin
                    m_q       <= bus.dividend / bus.divisor;
                    m_r       <= bus.dividend % bus.divisor;
                    m_z       <= 1'b0;
                    m_done_at <= cyc + N + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            checks++;
            if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder}
                !== {e_busy, e_done, e_dbz, e_q, e_r}) begin
                errors++;
                $display("FAIL outputs cyc=%0d actual busy=%b done=%b dbz=%b q=%h r=%h required busy=%b done=%b dbz=%b q=%h r=%h",
                         cyc, bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder,
                         e_busy, e_done, e_dbz, e_q, e_r);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic issue(input logic [N-1:0] dd, input logic [N-1:0] dv, output int acc);
        @(negedge clk);
        bus.dividend = dd;
        bus.divisor  = dv;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_done(input int acc, input string nm, output int lat);
        bit seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({nm, "_done_seen"}, 64'(seen), 64'd1);
        lat = cyc - acc;
    endtask

    task automatic do_div(input logic [N-1:0] dd, input logic [N-1:0] dv,
                          input logic [N-1:0] xq, input logic [N-1:0] xr,
                          input logic xz, input int xlat, input string nm);
        int acc, lat;
        issue(dd, dv, acc);
        chk({nm, "_busy"}, 64'(bus.busy), 64'd1);
        wait_done(acc, nm, lat);
        chk({nm, "_latency"}, 64'(lat), 64'(xlat));
        chk({nm, "_q"}, 64'(bus.quotient), 64'(xq));
        chk({nm, "_r"}, 64'(bus.remainder), 64'(xr));
        chk({nm, "_dbz"}, 64'(bus.div_by_zero), 64'(xz));
    endtask

    task automatic count_dones(input int n, input string nm);
        int cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) cnt++;
        end
        chk(nm, 64'(cnt), 64'd0);
    endtask

    task automatic rnd_ops(input bit nonzero, output logic [N-1:0] dd, output logic [N-1:0] dv);
        int sel = $urandom_range(0, 9);
        dd = $urandom;
        dv = $urandom;
        case (sel)
            0:       dv = '0;
            1, 2:    dv = N'($urandom_range(1, 16));
            3:       dd = N'($urandom_range(0, 50));
            4:       dd = '1;
            5:       dv = dd;
            default: ;
        endcase
        if (nonzero && dv == '0) dv = N'(1);
    endtask

    initial begin
        #900us;
        errors++;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int acc, lat, target, guard, nd;
        int done_cyc[3];
        logic [N-1:0] dd, dv;

        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_q", 64'(bus.quotient), 64'd0);
        chk("reset_r", 64'(bus.remainder), 64'd0);
        chk("reset_dbz", 64'(bus.div_by_zero), 64'd0);
        reset = 1'b0;

        do_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, "basic");
        do_div(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 33, "maxmax");
        do_div(32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 33, "small");
        do_div(32'hDEADBEEF, 32'd1, 32'hDEADBEEF, 32'd0, 1'b0, 33, "div1");
        do_div(32'd0, 32'd13, 32'd0, 32'd0, 1'b0, 33, "zero_num");
        do_div(32'h1234, 32'd0, 32'hFFFFFFFF, 32'h1234, 1'b1, 1, "dbz");
        do_div(32'd77, 32'd8, 32'd9, 32'd5, 1'b0, 33, "dbz_clear");

        // Second start mid-operation plus operand churn must not disturb the result.
        issue(32'd1000, 32'd10, acc);
        repeat (9) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd77;
        bus.divisor  = 32'd3;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = 32'd5555;
        bus.divisor  = 32'd2;
        wait_done(acc, "ignore", lat);
        chk("ignore_latency", 64'(lat), 64'd33);
        chk("ignore_q", 64'(bus.quotient), 64'd100);
        chk("ignore_r", 64'(bus.remainder), 64'd0);
        count_dones(40, "ignore_no_extra_done");

        // Abort by reset partway through.
        issue(32'd50, 32'd3, acc);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_q", 64'(bus.quotient), 64'd0);
        chk("abort_r", 64'(bus.remainder), 64'd0);
        count_dones(40, "abort_no_done");
        do_div(32'd81, 32'd9, 32'd9, 32'd0, 1'b0, 33, "after_abort");

        // Start held high: back-to-back divides every N+2 cycles.
        nd = 0;
        guard = 0;
        @(negedge clk);
        bus.start = 1'b1;
        while (nd < 3 && guard < 200) begin
            rnd_ops(1'b1, dd, dv);
            bus.dividend = dd;
            bus.divisor  = dv;
            @(negedge clk);
            guard++;
            if (bus.done === 1'b1) begin
                done_cyc[nd] = cyc;
                nd++;
            end
        end
        bus.start = 1'b0;
        chk("hold_dones", 64'(nd), 64'd3);
        if (nd == 3) begin
            chk("hold_gap1", 64'(done_cyc[1] - done_cyc[0]), 64'd34);
            chk("hold_gap2", 64'(done_cyc[2] - done_cyc[1]), 64'd34);
        end
        repeat (40) @(negedge clk);

        // 1000 random requests, operands churning every cycle.
        target = n_acc + 1000;
        guard  = 0;
        bus.start = 1'b1;
        while (n_acc < target && guard < 40000) begin
            rnd_ops(1'b0, dd, dv);
            bus.dividend = dd;
            bus.divisor  = dv;
            @(negedge clk);
            guard++;
        end
        bus.start = 1'b0;
        chk("random_requests_accepted", 64'(n_acc >= target), 64'd1);
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
